// File: rtl/regfile_rename_mp_pkg.sv
// Shared widths, types and tag layout for the renamed register file.
// Tag is {busy, rob_pos} with busy at the MSB.
package regfile_rename_mp_pkg;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int REG_W    = $clog2(NREG);
  localparam int ROB_W    = 4;
  localparam int TAG_W    = ROB_W + 1;
  localparam int ISSUE_W  = 2;
  localparam int COMMIT_W = 2;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] reg_t;
  typedef logic [ROB_W-1:0] pos_t;

  typedef struct packed {
    logic busy;
    pos_t pos;
  } tag_t;

  function automatic tag_t mk_tag(pos_t p);
    tag_t t;
    t.busy = 1'b1;
    t.pos  = p;
    return t;
  endfunction

endpackage

// File: rtl/regfile_rename_mp_if.sv
// Issue/commit bus between decoder, ROB and the register file.
// master = decoder/ROB side, slave = register file.
interface regfile_rename_mp_if;
  import regfile_rename_mp_pkg::*;

  logic [ISSUE_W-1:0]        iss_valid;
  reg_t [ISSUE_W-1:0]        iss_rd;
  pos_t [ISSUE_W-1:0]        iss_rob_pos;
  reg_t [ISSUE_W-1:0]        iss_rs1;
  reg_t [ISSUE_W-1:0]        iss_rs2;
  word_t [ISSUE_W-1:0]       rs1_val;
  word_t [ISSUE_W-1:0]       rs2_val;
  tag_t [ISSUE_W-1:0]        rs1_tag;
  tag_t [ISSUE_W-1:0]        rs2_tag;
  logic [COMMIT_W-1:0]       cmt_valid;
  reg_t [COMMIT_W-1:0]       cmt_rd;
  word_t [COMMIT_W-1:0]      cmt_val;
  pos_t [COMMIT_W-1:0]       cmt_rob_pos;

  modport master (
    output iss_valid, iss_rd, iss_rob_pos,
    output iss_rs1, iss_rs2,
    input  rs1_val, rs2_val, rs1_tag, rs2_tag,
    output cmt_valid, cmt_rd, cmt_val, cmt_rob_pos
  );

  modport slave (
    input  iss_valid, iss_rd, iss_rob_pos,
    input  iss_rs1, iss_rs2,
    output rs1_val, rs2_val, rs1_tag, rs2_tag,
    input  cmt_valid, cmt_rd, cmt_val, cmt_rob_pos
  );

endinterface

// File: rtl/regfile_src_fwd.sv
// Per-source operand mux: x0, older in-bundle producer,
// same-cycle matching commit, then stored state.
module regfile_src_fwd
  import regfile_rename_mp_pkg::*;
#(
  parameter int SLOT = 0
) (
  input  logic                 rst,
  input  reg_t                 src,
  input  word_t                sval,
  input  tag_t                 stag,
  input  logic [ISSUE_W-1:0]   iss_valid,
  input  reg_t [ISSUE_W-1:0]   iss_rd,
  input  pos_t [ISSUE_W-1:0]   iss_rob_pos,
  input  logic [COMMIT_W-1:0]  cmt_valid,
  input  reg_t [COMMIT_W-1:0]  cmt_rd,
  input  word_t [COMMIT_W-1:0] cmt_val,
  input  pos_t [COMMIT_W-1:0]  cmt_rob_pos,
  output word_t                val,
  output tag_t                 tag
);

  always_comb begin
    val = sval;
    tag = stag;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (cmt_valid[k] && cmt_rd[k] == src &&
          stag == mk_tag(cmt_rob_pos[k])) begin
        val = cmt_val[k];
        tag = '0;
      end
    end
    // Later loop wins: youngest older slot names the producer.
    for (int j = 0; j < SLOT; j++) begin
      if (iss_valid[j] && iss_rd[j] == src) begin
        val = sval;
        tag = mk_tag(iss_rob_pos[j]);
      end
    end
    if (!rst || src == '0) begin
      val = '0;
      tag = '0;
    end
  end

endmodule

// File: rtl/regfile_rename_mp.sv
// Multi-issue/multi-commit architectural register file with
// per-register rename tags, bypassing and rollback.
module regfile_rename_mp
  import regfile_rename_mp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rollback,
  regfile_rename_mp_if.slave bus
);

  word_t [NREG-1:0] val_q, val_d;
  tag_t  [NREG-1:0] tag_q, tag_d;

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (bus.cmt_valid[k]) begin
        val_d[bus.cmt_rd[k]] = bus.cmt_val[k];
        if (tag_q[bus.cmt_rd[k]] == mk_tag(bus.cmt_rob_pos[k]))
          tag_d[bus.cmt_rd[k]] = '0;
      end
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      if (bus.iss_valid[i])
        tag_d[bus.iss_rd[i]] = mk_tag(bus.iss_rob_pos[i]);
    end
    if (rollback)
      tag_d = '0;
    val_d[0] = '0;
    tag_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
      tag_q <= '0;
    end else if (rdy) begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
    regfile_src_fwd #(.SLOT(i)) u_rs1 (
      .rst         (rst),
      .src         (bus.iss_rs1[i]),
      .sval        (val_q[bus.iss_rs1[i]]),
      .stag        (tag_q[bus.iss_rs1[i]]),
      .iss_valid   (bus.iss_valid),
      .iss_rd      (bus.iss_rd),
      .iss_rob_pos (bus.iss_rob_pos),
      .cmt_valid   (bus.cmt_valid),
      .cmt_rd      (bus.cmt_rd),
      .cmt_val     (bus.cmt_val),
      .cmt_rob_pos (bus.cmt_rob_pos),
      .val         (bus.rs1_val[i]),
      .tag         (bus.rs1_tag[i])
    );

    regfile_src_fwd #(.SLOT(i)) u_rs2 (
      .rst         (rst),
      .src         (bus.iss_rs2[i]),
      .sval        (val_q[bus.iss_rs2[i]]),
      .stag        (tag_q[bus.iss_rs2[i]]),
      .iss_valid   (bus.iss_valid),
      .iss_rd      (bus.iss_rd),
      .iss_rob_pos (bus.iss_rob_pos),
      .cmt_valid   (bus.cmt_valid),
      .cmt_rd      (bus.cmt_rd),
      .cmt_val     (bus.cmt_val),
      .cmt_rob_pos (bus.cmt_rob_pos),
      .val         (bus.rs2_val[i]),
      .tag         (bus.rs2_tag[i])
    );
  end

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Directed bench for regfile_rename_mp with hand-computed
// expectations for forwarding, commit, stale commit, rollback.
module tb_regfile_rename_mp;
  import regfile_rename_mp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rollback;
  int   errs = 0;
  int   checks = 0;

  regfile_rename_mp_if bus();

  regfile_rename_mp dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle();
    bus.iss_valid   = '0;
    bus.iss_rd      = '0;
    bus.iss_rob_pos = '0;
    bus.iss_rs1     = '0;
    bus.iss_rs2     = '0;
    bus.cmt_valid   = '0;
    bus.cmt_rd      = '0;
    bus.cmt_val     = '0;
    bus.cmt_rob_pos = '0;
    rollback        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(string n, reg_t r, word_t v,
                        logic [4:0] t);
    idle();
    bus.iss_rs2[1] = r;
    #1;
    chk({n, "_val"}, bus.rs2_val[1], v);
    chk({n, "_tag"}, 32'(bus.rs2_tag[1]), 32'(t));
  endtask

  initial begin
    rdy = 1'b1;
    rst = 1'b1;
    idle();
    #1 rst = 1'b0;
    bus.iss_rs1[0] = 5'd5;
    #1;
    chk("rst_val", bus.rs1_val[0], 32'h0);
    chk("rst_tag", 32'(bus.rs1_tag[0]), 32'h0);
    rst = 1'b1;
    tick();

    // in-bundle forward of slot0 producer to slot1
    idle();
    bus.iss_valid[0]   = 1'b1;
    bus.iss_rd[0]      = 5'd3;
    bus.iss_rob_pos[0] = 4'd2;
    bus.iss_rs1[1]     = 5'd3;
    bus.iss_rs1[0]     = 5'd3;
    #1;
    chk("ib_fwd_tag", 32'(bus.rs1_tag[1]), 32'h12);
    chk("ib_self_tag", 32'(bus.rs1_tag[0]), 32'h0);
    tick();
    rd_chk("x3_busy", 5'd3, 32'h0, 5'h12);

    // commit bypass
    idle();
    bus.cmt_valid[0]   = 1'b1;
    bus.cmt_rd[0]      = 5'd3;
    bus.cmt_rob_pos[0] = 4'd2;
    bus.cmt_val[0]     = 32'hDEADBEEF;
    bus.iss_rs1[0]     = 5'd3;
    #1;
    chk("cm_byp_val", bus.rs1_val[0], 32'hDEADBEEF);
    chk("cm_byp_tag", 32'(bus.rs1_tag[0]), 32'h0);
    tick();
    rd_chk("x3_done", 5'd3, 32'hDEADBEEF, 5'h00);

    // commit plus reissue on x3
    idle();
    bus.iss_valid[0]   = 1'b1;
    bus.iss_rd[0]      = 5'd3;
    bus.iss_rob_pos[0] = 4'd2;
    tick();
    idle();
    bus.cmt_valid[0]   = 1'b1;
    bus.cmt_rd[0]      = 5'd3;
    bus.cmt_rob_pos[0] = 4'd2;
    bus.cmt_val[0]     = 32'h12345678;
    bus.iss_valid[0]   = 1'b1;
    bus.iss_rd[0]      = 5'd3;
    bus.iss_rob_pos[0] = 4'd7;
    bus.iss_rs1[1]     = 5'd3;
    #1;
    chk("set_prio_tag", 32'(bus.rs1_tag[1]), 32'h17);
    tick();
    rd_chk("x3_reiss", 5'd3, 32'h12345678, 5'h17);

    // two commits to x4, younger wins
    idle();
    bus.cmt_valid   = 2'b11;
    bus.cmt_rd[0]   = 5'd4;
    bus.cmt_val[0]  = 32'd1;
    bus.cmt_rd[1]   = 5'd4;
    bus.cmt_val[1]  = 32'd2;
    tick();
    rd_chk("x4_dup", 5'd4, 32'd2, 5'h00);

    // stale commit on x8
    idle();
    bus.iss_valid[1]   = 1'b1;
    bus.iss_rd[1]      = 5'd8;
    bus.iss_rob_pos[1] = 4'd9;
    tick();
    idle();
    bus.cmt_valid[0]   = 1'b1;
    bus.cmt_rd[0]      = 5'd8;
    bus.cmt_rob_pos[0] = 4'd4;
    bus.cmt_val[0]     = 32'h11;
    bus.iss_rs1[0]     = 5'd8;
    #1;
    chk("stale_rd_val", bus.rs1_val[0], 32'h0);
    chk("stale_rd_tag", 32'(bus.rs1_tag[0]), 32'h19);
    tick();
    rd_chk("x8_stale", 5'd8, 32'h11, 5'h19);

    // x0 is never renamed or written
    idle();
    bus.iss_valid[0]   = 1'b1;
    bus.iss_rd[0]      = 5'd0;
    bus.iss_rob_pos[0] = 4'd3;
    bus.cmt_valid[1]   = 1'b1;
    bus.cmt_rd[1]      = 5'd0;
    bus.cmt_val[1]     = 32'h99;
    bus.iss_rs1[1]     = 5'd0;
    #1;
    chk("x0_fwd_tag", 32'(bus.rs1_tag[1]), 32'h0);
    tick();
    rd_chk("x0", 5'd0, 32'h0, 5'h00);

    // rdy=0 freezes everything
    for (int pass = 0; pass < 2; pass++) begin
      idle();
      rdy                = (pass == 1);
      rollback           = 1'b1;
      bus.iss_valid[0]   = 1'b1;
      bus.iss_rd[0]      = 5'd9;
      bus.iss_rob_pos[0] = 4'd5;
      bus.cmt_valid[0]   = 1'b1;
      bus.cmt_rd[0]      = 5'd6;
      bus.cmt_val[0]     = 32'h55;
      tick();
      rdy = 1'b1;
      if (pass == 0) begin
        rd_chk("frz_x6", 5'd6, 32'h0, 5'h00);
        rd_chk("frz_x8", 5'd8, 32'h11, 5'h19);
        rd_chk("frz_x3", 5'd3, 32'h12345678, 5'h17);
      end else begin
        rd_chk("rb_x6", 5'd6, 32'h55, 5'h00);
        rd_chk("rb_x8", 5'd8, 32'h11, 5'h00);
        rd_chk("rb_x3", 5'd3, 32'h12345678, 5'h00);
        rd_chk("rb_x9", 5'd9, 32'h0, 5'h00);
      end
    end

    // async reset while x5 busy
    idle();
    bus.iss_valid[0]   = 1'b1;
    bus.iss_rd[0]      = 5'd5;
    bus.iss_rob_pos[0] = 4'd6;
    tick();
    rd_chk("x5_busy", 5'd5, 32'h0, 5'h16);
    rst = 1'b0;
    rd_chk("rst_x5", 5'd5, 32'h0, 5'h00);
    rd_chk("rst_x3", 5'd3, 32'h0, 5'h00);
    idle();
    bus.iss_valid[0]   = 1'b1;
    bus.iss_rd[0]      = 5'd5;
    bus.iss_rob_pos[0] = 4'd6;
    bus.iss_rs1[1]     = 5'd5;
    #1;
    chk("rst_ib_tag", 32'(bus.rs1_tag[1]), 32'h0);
    idle();
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/regfile_rename_mp.md
Name: regfile_rename_mp

Overview:
Multi-issue, multi-commit architectural register file with rename tags for the out-of-order core. It holds committed values and, per register, the ROB position of its youngest in-flight producer. Decoder slots query source operands, and the block forwards same-cycle commits and intra-bundle producers. It sits between decoder (issue side) and reorder buffer (commit side), and clears all tags on rollback.

Parameters:
XLEN, 32, data width
NREG, 32, architectural register count (power of 2); REG_W = clog2(NREG) derived
ROB_W, 4, ROB position width; tag width = ROB_W+1 ({busy, pos})
ISSUE_W, 2, decoder slots per cycle (slot 0 oldest)
COMMIT_W, 2, ROB commit slots per cycle (slot 0 oldest)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global enable; 0 freezes all state
rollback  in  1  flush: clear every rename tag
iss_valid  in  ISSUE_W  slot i issues an instruction
iss_rd  in  ISSUE_W*REG_W  destination register per slot
iss_rob_pos  in  ISSUE_W*ROB_W  ROB position allocated per slot
iss_rs1, iss_rs2  in  ISSUE_W*REG_W  source registers per slot
rs1_val, rs2_val  out  ISSUE_W*XLEN  source value (valid when tag busy=0)
rs1_tag, rs2_tag  out  ISSUE_W*(ROB_W+1)  {busy, rob_pos} of pending producer
cmt_valid  in  COMMIT_W  commit slot k retires
cmt_rd  in  COMMIT_W*REG_W  destination register
cmt_val  in  COMMIT_W*XLEN  result value
cmt_rob_pos  in  COMMIT_W*ROB_W  ROB position being retired

Behaviour:
- State: val[NREG] (XLEN), tag[NREG] ({busy,pos}). Register 0 is never written; it reads val 0, tag 0.
- Reset (rst=0, async): all val=0, all tag=0. Outputs are combinational and read 0/not-busy while in reset.
- Read path (combinational, zero latency), for slot i and source s, in priority order:
  1. s==0 -> val 0, tag 0.
  2. Some iss_valid[j] with j<i and iss_rd[j]==s -> tag {1, iss_rob_pos[j]} from the largest such j; val don't-care (drive stored val).
  3. Some cmt_valid[k] with cmt_rd[k]==s and tag[s]=={1, cmt_rob_pos[k]} (pre-update tag) -> val cmt_val[k], tag 0.
  4. Otherwise stored val[s], tag[s].
- Reads ignore rollback. The decoder must not issue in a rollback cycle.
- Sequential update on posedge clk when rdy=1:
  - Value write: for each rd != 0, the highest k with cmt_valid[k] and cmt_rd[k]==rd writes val[rd]=cmt_val[k]. Older same-rd commits are discarded.
  - Tag clear: tag[rd]<=0 if some committing k on rd has {1,cmt_rob_pos[k]}==tag[rd] (pre-update) and no issue this cycle targets rd.
  - Tag set: for each rd != 0, the highest i with iss_valid[i] and iss_rd[i]==rd sets tag[rd]={1,iss_rob_pos[i]}. Set beats clear.
  - Rollback: all tags go to 0 and issue writes are suppressed. Commit value writes in the same cycle still occur.
- rdy=0: no state change, regardless of the valid or rollback inputs.
- A commit whose rob_pos does not match the current tag updates val only; the tag keeps naming the younger producer.
- No handshake: every valid is a one-cycle pulse, accepted unconditionally.

Decomposition:
- Shared package/include holds XLEN, NREG, ROB_W defaults, REG_W derivation, and the tag layout (busy bit at MSB, TAG_W = ROB_W+1).
- One natural sub-module, regfile_src_fwd: per-source forwarding mux (priority steps 1-4), instantiated 2*ISSUE_W times.
- Top holds the storage arrays and the update loop.

Test Plan:
- Reset mid-operation: rst=0 while x5 tag busy -> immediately rs1_tag 0 and val 0 for x5, with no clock needed.
- Issue slot0 rd=x3 pos=2, slot1 rs1=x3, same cycle -> slot1 rs1_tag={1,2}. Next cycle, any slot reading x3 sees {1,2}.
- Commit x3 pos=2 val=0xDEADBEEF while slot0 reads x3 -> rs1_val=0xDEADBEEF, tag 0 in the same cycle. Next cycle stored tag is 0.
- Same-cycle commit x3 pos=2 plus issue x3 pos=7 -> val[x3]=commit value, tag[x3]={1,7}. A commit slot0 x4=1 and slot1 x4=2 -> val[x4]=2.
- Stale commit: tag[x8]={1,9}, commit x8 pos=4 val=0x11 -> val[x8]=0x11, tag stays {1,9}, and reads return busy.
- rollback=1 with iss_valid and a commit on x6 val=0x55 -> all tags 0, val[x6]=0x55, no issue tag set. With rdy=0, the same stimulus leaves the state unchanged.
